// File: rtl/bit_splitter_pkg.sv
// Shared types and defaults for the bit splitter.
// Optional popcount output is enabled by BIT_SPLITTER_COUNT_EN.
package bit_splitter_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int IDX_W_DEF = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    localparam logic [WIDTH_DEF-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/bit_splitter_lsb_find.sv
// Lowest-set-bit finder built from plain and/or/not terms.
// Returns the isolated bit, its binary index and a single-bit flag.
module lsb_find
    import bit_splitter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_onehot,
    output logic [IDX_W-1:0] o_index,
    output logic             o_single
);

    logic [WIDTH-1:0] w_onehot;
    logic [WIDTH-1:0] w_dup;
    logic [IDX_W-1:0] w_index;
    logic             w_any;

    // w_any walks upward as "some lower bit was already set"
    always_comb begin
        w_onehot = '0;
        w_dup    = '0;
        w_index  = '0;
        w_any    = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_onehot[i] = i_mask[i] & ~w_any;
            w_dup[i]    = i_mask[i] & w_any;
            w_any       = w_any | i_mask[i];
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_index = w_index | ({IDX_W{w_onehot[i]}} & IDX_W'(i));
        end
    end

    assign o_onehot = w_onehot;
    assign o_index  = w_index;
    assign o_single = w_any & ~(|w_dup);

endmodule

// File: rtl/bit_splitter.sv
// Splits a merged word into one-hot beats, lowest bit first.
// Define BIT_SPLITTER_COUNT_EN to add the out_count popcount port.
module bit_splitter
    import bit_splitter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
`ifdef BIT_SPLITTER_COUNT_EN
    output logic [IDX_W:0]   out_count,
`endif
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_mask_nxt;

    logic [WIDTH-1:0] w_lsb_onehot;
    logic [IDX_W-1:0] w_lsb_index;
    logic             w_lsb_single;
    logic             w_empty;
    logic             w_last;
    logic             w_split;
    logic             w_ready;

    lsb_find #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_lsb (
        .i_mask   (r_mask),
        .o_onehot (w_lsb_onehot),
        .o_index  (w_lsb_index),
        .o_single (w_lsb_single)
    );

    // an empty word still owes one terminating beat
    assign w_empty = (r_mask == WIDTH'(ZERO_WORD));
    assign w_last  = w_lsb_single | w_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_ready     = 1'b0;
        w_split     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = ~reset;
                if (in_valid & ~reset) begin
                    w_mask_nxt  = data_operand;
                    w_state_nxt = SPLIT;
                end
            end
            SPLIT: begin
                w_split = 1'b1;
                if (out_ready) begin
                    w_mask_nxt = r_mask & ~w_lsb_onehot;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_mask_nxt  = '0;
            end
        endcase
    end

    assign in_ready   = w_ready;
    assign out_valid  = w_split;
    assign busy       = w_split;
    assign out_onehot = w_lsb_onehot & {WIDTH{w_split}};
    assign out_index  = w_lsb_index & {IDX_W{w_split}};
    assign out_last   = w_last & w_split;

`ifdef BIT_SPLITTER_COUNT_EN
    logic [IDX_W:0] r_count;
    logic [IDX_W:0] w_popcnt;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcnt = w_popcnt + (IDX_W+1)'(data_operand[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_ready & in_valid) begin
            r_count <= w_popcnt;
        end
    end

    assign out_count = r_count;
`endif

endmodule

// File: tb/tb_bit_splitter.sv
// Randomized bench for bit_splitter with a queue-based beat model.
// Build with BIT_SPLITTER_COUNT_EN to also check out_count.
module tb_bit_splitter;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_onehot;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
`ifdef BIT_SPLITTER_COUNT_EN
    logic [5:0]  out_count;
`endif

    int checks = 0;
    int errors = 0;

    bit_splitter dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_operand (data_operand),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_onehot   (out_onehot),
        .out_index    (out_index),
        .out_last     (out_last),
`ifdef BIT_SPLITTER_COUNT_EN
        .out_count    (out_count),
`endif
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_word;
        logic [31:0] w;
        case ($urandom % 5)
            0: w = 32'h0;
            1: w = 32'hFFFF_FFFF;
            2: w = 32'h1 << ($urandom % 32);
            3: w = $urandom & $urandom & $urandom;
            default: w = $urandom;
        endcase
        return w;
    endfunction

    typedef struct {
        logic [31:0] oh;
        int          idx;
        logic        last;
    } beat_t;

    beat_t q[$];
    int    m_count = 0;
    bit    prev_rst = 1'b1;

    // model: a word becomes its list of beats, consumed on each transfer
    always @(negedge clock) begin
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(!reset && q.size() == 0));
        if (q.size() != 0) begin
            chk("onehot", out_onehot, q[0].oh);
            chk("index", 32'(out_index), 32'(q[0].idx));
            chk("last", 32'(out_last), 32'(q[0].last));
        end else if (prev_rst) begin
            chk("rst_onehot", out_onehot, 32'h0);
            chk("rst_index", 32'(out_index), 32'h0);
            chk("rst_last", 32'(out_last), 32'h0);
        end
`ifdef BIT_SPLITTER_COUNT_EN
        chk("count", 32'(out_count), 32'(m_count));
`endif
        prev_rst = reset;
        if (reset) begin
            q.delete();
            m_count = 0;
        end else if (q.size() != 0) begin
            if (out_ready) void'(q.pop_front());
        end else if (in_valid) begin
            m_count = $countones(data_operand);
            if (data_operand == 32'h0) begin
                q.push_back('{32'h0, 0, 1'b1});
            end else begin
                for (int i = 0; i < 32; i++) begin
                    if (data_operand[i]) q.push_back('{32'h1 << i, i, 1'b0});
                end
                q[q.size()-1].last = 1'b1;
            end
        end
    end

    initial begin
        int k;
        reset        = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        data_operand = 32'h0;
        tick;
        tick;
        chk("lit_rst_in_ready", 32'(in_ready), 32'h0);
        chk("lit_rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        #1;
        chk("lit_in_ready_up", 32'(in_ready), 32'h1);

        in_valid = 1'b1;
        data_operand = 32'h5;
        tick;
        in_valid = 1'b0;
        data_operand = $urandom;
        chk("lit5_oh0", out_onehot, 32'h1);
        chk("lit5_idx0", 32'(out_index), 32'd0);
        chk("lit5_last0", 32'(out_last), 32'h0);
        chk("lit5_ready0", 32'(in_ready), 32'h0);
        tick;
        chk("lit5_oh1", out_onehot, 32'h4);
        chk("lit5_idx1", 32'(out_index), 32'd2);
        chk("lit5_last1", 32'(out_last), 32'h1);
        tick;
        chk("lit5_ready_back", 32'(in_ready), 32'h1);

        in_valid = 1'b1;
        data_operand = 32'h0;
        tick;
        in_valid = 1'b0;
        chk("litz_busy", 32'(busy), 32'h1);
        chk("litz_oh", out_onehot, 32'h0);
        chk("litz_last", 32'(out_last), 32'h1);
        tick;
        chk("litz_busy_off", 32'(busy), 32'h0);

        in_valid = 1'b1;
        data_operand = 32'hFFFF_FFFF;
        tick;
        for (int i = 0; i < 32; i++) begin
            data_operand = $urandom;
            chk("ones_idx", 32'(out_index), 32'(i));
            chk("ones_last", 32'(out_last), 32'(i == 31));
            chk("ones_ready", 32'(in_ready), 32'h0);
            if (i == 31) in_valid = 1'b0;
            tick;
        end
        chk("ones_ready_back", 32'(in_ready), 32'h1);

        in_valid = 1'b1;
        data_operand = 32'h8000_0010;
        tick;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin
            chk("bp_oh", out_onehot, 32'h10);
            chk("bp_idx", 32'(out_index), 32'd4);
            tick;
        end
        out_ready = 1'b1;
        tick;
        chk("bp_oh2", out_onehot, 32'h8000_0000);
        chk("bp_idx2", 32'(out_index), 32'd31);
        chk("bp_last2", 32'(out_last), 32'h1);
        tick;

        in_valid = 1'b1;
        data_operand = 32'hF0;
        tick;
        in_valid = 1'b0;
        tick;
        chk("ab_idx", 32'(out_index), 32'd5);
        reset = 1'b1;
        tick;
        chk("ab_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;
        #1;
        chk("ab_ready", 32'(in_ready), 32'h1);
        tick;
        chk("ab_quiet", 32'(out_valid), 32'h0);

`ifdef BIT_SPLITTER_COUNT_EN
        in_valid = 1'b1;
        data_operand = 32'h0F0F_0001;
        tick;
        in_valid = 1'b0;
        chk("lit_count", 32'(out_count), 32'd9);
        repeat (12) tick;
        chk("lit_count_hold", 32'(out_count), 32'd9);
`endif

        for (int n = 0; n < 600; n++) begin
            in_valid     = 1'($urandom % 2);
            data_operand = rand_word();
            out_ready    = ($urandom % 4) != 0;
            reset        = ($urandom % 80) == 0;
            tick;
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (!in_ready && k < 40) begin
            tick;
            k++;
        end
        chk("drain", 32'(in_ready), 32'h1);
        tick;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
